// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, load/store
// type encodings (funct3-based, shared with load_store_unit) and the
// alignment / legality check applied at request acceptance.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Misaligned halves/words and unused type encodings raise a fault.
  function automatic logic access_fault(input logic       wr,
                                        input logic [1:0] off,
                                        input logic [2:0] lt,
                                        input logic [1:0] st);
    logic f;
    f = 1'b1;
    if (wr) begin
      case (st)
        ST_SB:   f = 1'b0;
        ST_SH:   f = off[0];
        ST_SW:   f = |off;
        default: f = 1'b1;
      endcase
    end else begin
      case (lt)
        LT_LB, LT_LBU: f = 1'b0;
        LT_LH, LT_LHU: f = off[0];
        LT_LW:         f = |off;
        default:       f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks the addressed byte or halfword out
// of a 32-bit SRAM word and sign- or zero-extends it by load type.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ltype_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension.
  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (ltype_i)
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data_o = {24'h0, byte_sel};
      LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle RV32I core: accepts one load
// or store at a time, checks alignment, drives a fixed-latency word SRAM
// with byte enables and returns load data / store ack via valid/ready.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int WORD_ADDR_W = 14
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [2:0]             LoadType,
  input  logic [1:0]             StoreType,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_fault,
  output logic                   sram_en,
  output logic                   sram_we,
  output logic [3:0]             sram_be,
  output logic [WORD_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [1:0]             off_q, off_d;
  logic [2:0]             ltype_q, ltype_d;
  logic                   sram_en_q, sram_en_d;
  logic                   sram_we_q, sram_we_d;
  logic [3:0]             sram_be_q, sram_be_d;
  logic [WORD_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]            sram_wdata_q, sram_wdata_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_fault_q, resp_fault_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;

  logic                   req_fault;
  logic [3:0]             st_be;
  logic [31:0]            st_wdata;
  logic [31:0]            ld_data;
  logic                   unused_addr;

  assign unused_addr = ^req_addr[31:WORD_ADDR_W+2];

  load_extend u_load_extend (
    .word_i  (sram_rdata),
    .off_i   (off_q),
    .ltype_i (ltype_q),
    .data_o  (ld_data)
  );

  // Request decode: fault check, byte enables and lane-replicated store data.
  always_comb begin
    req_fault = access_fault(req_write, req_addr[1:0], LoadType, StoreType);
    st_be     = 4'hF;
    st_wdata  = req_wdata;
    case (StoreType)
      ST_SB: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      ST_SH: begin
        st_be    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Next-state and next-output logic; all outputs but req_ready are registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    off_d        = off_q;
    ltype_d      = ltype_q;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_be_d    = '0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_fault_d = resp_fault_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          off_d       = req_addr[1:0];
          ltype_d     = LoadType;
          sram_addr_d = req_addr[WORD_ADDR_W+1:2];
          if (req_fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
            state_d      = S_RESP;
          end else begin
            sram_en_d = 1'b1;
            sram_we_d = req_write;
            sram_be_d = req_write ? st_be : 4'hF;
            if (req_write) sram_wdata_d = st_wdata;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (write_q) begin
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
          state_d      = S_RESP;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      // Loads always pass through WAIT, which lasts WAIT_STATES cycles so the
      // capture edge is the one on which sram_rdata first becomes valid.
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = ld_data;
          cnt_d        = '0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      off_q        <= '0;
      ltype_q      <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      off_q        <= off_d;
      ltype_q      <= ltype_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_be_q    <= sram_be_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_be    = sram_be_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule
